wr_arria10_xcvr_rst_seq: RTL and testbench
==========================================

# wr_arria10_xcvr_rst_seq

Soft reset sequencer for the Arria 10 transceiver channel used by the WR PHY. It drives the PLL, TX and RX analog and digital resets from PLL lock, calibration-busy and CDR lock status, and reports link readiness. It includes CDR-lock timeout and retry, and runtime re-sequencing requests. It sits between the WR PHY top level and the native transceiver/ATX PLL instances.

## Interface
- G_PLL_PD_CYCLES, 1000: pll_powerdown pulse width, in clock cycles.
- G_ANALOG_MIN_CYCLES, 700: minimum rx_analogreset assertion, in cycles.
- G_TX_LOCK_CYCLES, 100: pll_locked must be continuously high for this many cycles before tx_digitalreset is released.
- G_RX_LTD_CYCLES, 4000: rx_is_lockedtodata must be continuously high for this many cycles before rx_digitalreset is released.
- G_CDR_TIMEOUT, 200000: cycles allowed in RX_WAIT_CDR before the RX analog reset is restarted.
- clock  in  1  free-running system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high; resets the whole block.
- tx_reset_req  in  1  synchronous pulse; restarts the TX sequence from TX_PLL_PD, and with it the RX sequence.
- rx_reset_req  in  1  synchronous pulse; restarts the RX sequence from RX_ANALOG.
- pll_locked  in  1  asynchronous ATX PLL lock status.
- tx_cal_busy  in  1  asynchronous TX calibration busy.
- rx_is_lockedtodata  in  1  asynchronous CDR lock status.
- rx_cal_busy  in  1  asynchronous RX calibration busy.
- pll_powerdown, tx_analogreset, tx_digitalreset  out  1 each  TX-side resets.
- rx_analogreset, rx_digitalreset  out  1 each  RX-side resets.
- tx_ready, rx_ready  out  1 each  channel ready flags.
- rx_retry_cnt  out  8  saturating count of CDR timeouts since reset.

## Operation
- The four asynchronous status inputs each pass through a 2-flop synchronizer. The FSMs see them 2 cycles late.
- All outputs are registered.
- Reset values:
  - pll_powerdown, tx_analogreset, tx_digitalreset, rx_analogreset and rx_digitalreset are 1.
  - tx_ready and rx_ready are 0.
  - rx_retry_cnt is 0.
  - Both FSMs start at their first state with the counter at 0.
- TX FSM:
  - TX_PLL_PD: all TX resets are 1. Count G_PLL_PD_CYCLES, then go to TX_CAL.
  - TX_CAL: pll_powerdown=0; analog and digital resets stay 1. When tx_cal_busy=0, go to TX_LOCK.
  - TX_LOCK: tx_analogreset=0. The counter runs while pll_locked=1 and clears whenever pll_locked=0. When it reaches G_TX_LOCK_CYCLES, go to TX_READY.
  - TX_READY: tx_digitalreset=0 and tx_ready=1. If pll_locked=0, set tx_digitalreset=1 and tx_ready=0 and return to TX_LOCK.
- RX FSM. RX sequencing is gated by tx_ready; rx_analogreset releases only while tx_ready=1.
  - RX_ANALOG: rx_analogreset=1, rx_digitalreset=1. Leave when the counter ≥ G_ANALOG_MIN_CYCLES, rx_cal_busy=0 and tx_ready=1; go to RX_WAIT_CDR.
  - RX_WAIT_CDR: rx_analogreset=0, rx_digitalreset=1. A stability counter runs while rx_is_lockedtodata=1 and clears on 0. A separate timeout counter runs throughout.
    - Stability counter reaches G_RX_LTD_CYCLES: go to RX_READY.
    - Timeout counter reaches G_CDR_TIMEOUT: rx_retry_cnt++ (saturates at 255), go to RX_ANALOG.
  - RX_READY: rx_digitalreset=0, rx_ready=1.
    - rx_is_lockedtodata=0: go to RX_WAIT_CDR with both counters cleared.
    - tx_ready falls: go to RX_ANALOG.
- Priority on each edge: reset > tx_reset_req > rx_reset_req > normal transitions.
  - tx_reset_req forces the TX FSM to TX_PLL_PD and the RX FSM to RX_ANALOG.
  - rx_reset_req arriving together with tx_reset_req is absorbed.
- Counters clear on every state entry.
- Counter width is clog2 of the largest parameter + 1. Counters never wrap: each holds at its terminal value until the transition is taken.
- Any reset request mid-sequence aborts the current sequence immediately, with no partial release.

## Timing
- After reset deasserts, pll_powerdown falls on rising edge G_PLL_PD_CYCLES, counting the first edge after release as edge 1.
- tx_analogreset falls 1 cycle after TX_CAL sees tx_cal_busy=0. That is 3 edges after the pin changes (2 for the synchronizer, 1 for the state change).
- tx_digitalreset falls, and tx_ready rises, on the same edge. That edge is G_TX_LOCK_CYCLES+1 edges after TX_LOCK entry when pll_locked is already stable.
- Loss of lock (pll_locked or rx_is_lockedtodata pin falling) asserts the matching digital reset and drops the matching ready flag 3 edges later.
- rx_ready rises on the same edge that rx_digitalreset falls.
- An asserted reset request takes effect on the next edge: outputs show the reset state 1 cycle after the request is sampled.

## Test plan
Sim parameters for all scenarios: PLL_PD=8, ANALOG_MIN=6, TX_LOCK=4, RX_LTD=10, CDR_TIMEOUT=50.
1. Nominal bring-up. Status pins all good from time 0.
   - pll_powerdown falls at edge 8.
   - tx_ready rises after the lock window.
   - rx_ready rises after ANALOG_MIN plus RX_LTD.
   - rx_retry_cnt stays 0.
2. CDR never locks (rx_is_lockedtodata held 0 for 300 cycles).
   - rx_analogreset re-pulses every timeout.
   - rx_retry_cnt increments by 1 per timeout; rx_ready stays 0.
3. Glitchy CDR. rx_is_lockedtodata=1 for 9 cycles, 0 for 1 cycle, then held 1.
   - rx_ready rises only after 10 contiguous high cycles following the glitch.
4. pll_locked drops for 5 cycles while both sides are ready.
   - tx_ready and rx_ready go to 0.
   - RX restarts from RX_ANALOG.
   - Recovery follows without any pll_powerdown pulse.
5. tx_reset_req pulse mid-RX_WAIT_CDR.
   - Next edge: all five resets are 1 and both ready flags are 0.
   - pll_powerdown holds for 8 cycles.
6. Async reset asserted mid-TX_LOCK.
   - All outputs return to their reset values immediately, without waiting for a clock edge.
   - rx_retry_cnt is 0.

Source files
------------

// File: rtl/wr_arria10_xcvr_rst_seq.sv
// Soft reset sequencer for an Arria 10 transceiver channel (WR PHY).
// Drives PLL, TX and RX analog/digital resets from PLL lock, calibration
// busy and CDR lock status, with CDR-lock timeout/retry and runtime
// re-sequencing requests.
//
// Ports:
//   clock_i               free-running system clock (rising edge)
//   reset_i               asynchronous active-high block reset
//   tx_reset_req_i        sync pulse: restart TX (and RX) sequence
//   rx_reset_req_i        sync pulse: restart RX sequence
//   pll_locked_i          async ATX PLL lock status
//   tx_cal_busy_i         async TX calibration busy
//   rx_is_lockedtodata_i  async CDR lock status
//   rx_cal_busy_i         async RX calibration busy
//   pll_powerdown_o, tx_analogreset_o, tx_digitalreset_o   TX-side resets
//   rx_analogreset_o, rx_digitalreset_o                    RX-side resets
//   tx_ready_o, rx_ready_o                                 ready flags
//   rx_retry_cnt_o        saturating count of CDR timeouts since reset
//
// TX FSM
//   state      | meaning
//   TX_PLL_PD  | PLL powered down, all TX resets held
//   TX_CAL     | PLL powered, waiting for TX calibration to finish
//   TX_LOCK    | analog released, waiting for stable PLL lock
//   TX_READY   | digital released, TX usable
// RX FSM
//   state       | meaning
//   RX_ANALOG   | analog reset held for a minimum time, waiting on TX/cal
//   RX_WAIT_CDR | analog released, waiting for stable CDR lock or timeout
//   RX_READY    | digital released, RX usable
module wr_arria10_xcvr_rst_seq #(
    parameter int G_PLL_PD_CYCLES     = 1000,
    parameter int G_ANALOG_MIN_CYCLES = 700,
    parameter int G_TX_LOCK_CYCLES    = 100,
    parameter int G_RX_LTD_CYCLES     = 4000,
    parameter int G_CDR_TIMEOUT       = 200000
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       tx_reset_req_i,
    input  logic       rx_reset_req_i,
    input  logic       pll_locked_i,
    input  logic       tx_cal_busy_i,
    input  logic       rx_is_lockedtodata_i,
    input  logic       rx_cal_busy_i,
    output logic       pll_powerdown_o,
    output logic       tx_analogreset_o,
    output logic       tx_digitalreset_o,
    output logic       rx_analogreset_o,
    output logic       rx_digitalreset_o,
    output logic       tx_ready_o,
    output logic       rx_ready_o,
    output logic [7:0] rx_retry_cnt_o
);

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int C_MAX = max2(max2(max2(G_PLL_PD_CYCLES, G_ANALOG_MIN_CYCLES),
                                     max2(G_TX_LOCK_CYCLES, G_RX_LTD_CYCLES)),
                                G_CDR_TIMEOUT);
    localparam int CNT_W = $clog2(C_MAX) + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    // PLL powerdown transitions on the edge that would make the count reach
    // its length, so pll_powerdown spans exactly G_PLL_PD_CYCLES cycles.
    localparam cnt_t C_PD_LAST = cnt_t'(G_PLL_PD_CYCLES - 1);
    localparam cnt_t C_TX_LOCK = cnt_t'(G_TX_LOCK_CYCLES);
    localparam cnt_t C_ANA_MIN = cnt_t'(G_ANALOG_MIN_CYCLES);
    localparam cnt_t C_RX_LTD  = cnt_t'(G_RX_LTD_CYCLES);
    localparam cnt_t C_CDR_TMO = cnt_t'(G_CDR_TIMEOUT);

    typedef enum logic [1:0] {TX_PLL_PD, TX_CAL, TX_LOCK, TX_READY} tx_state_t;
    typedef enum logic [1:0] {RX_ANALOG, RX_WAIT_CDR, RX_READY} rx_state_t;

    // Bit order: {rx_cal_busy, rx_is_lockedtodata, tx_cal_busy, pll_locked}.
    // Busy flags reset to 1 so nothing is released before real status arrives.
    localparam logic [3:0] C_SYNC_RST = 4'b1010;

    logic [3:0] sync1_q, sync2_q;
    logic       pll_locked_s, tx_cal_busy_s, rx_ltd_s, rx_cal_busy_s;

    tx_state_t  tx_state_q, tx_state_d;
    rx_state_t  rx_state_q, rx_state_d;
    cnt_t       tx_cnt_q, tx_cnt_d;
    cnt_t       rx_cnt_q, rx_cnt_d;
    cnt_t       rx_tmo_q, rx_tmo_d;
    logic [7:0] retry_q, retry_d;

    logic pll_pd_q, pll_pd_d;
    logic tx_ana_q, tx_ana_d;
    logic tx_dig_q, tx_dig_d;
    logic rx_ana_q, rx_ana_d;
    logic rx_dig_q, rx_dig_d;
    logic tx_rdy_q, tx_rdy_d;
    logic rx_rdy_q, rx_rdy_d;

    assign pll_locked_s  = sync2_q[0];
    assign tx_cal_busy_s = sync2_q[1];
    assign rx_ltd_s      = sync2_q[2];
    assign rx_cal_busy_s = sync2_q[3];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= C_SYNC_RST;
            sync2_q <= C_SYNC_RST;
        end else begin
            sync1_q <= {rx_cal_busy_i, rx_is_lockedtodata_i, tx_cal_busy_i, pll_locked_i};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        if (tx_reset_req_i) begin
            tx_state_d = TX_PLL_PD;
            tx_cnt_d   = '0;
        end else begin
            case (tx_state_q)
                TX_PLL_PD: begin
                    if (tx_cnt_q == C_PD_LAST) begin
                        tx_state_d = TX_CAL;
                        tx_cnt_d   = '0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
                TX_CAL: begin
                    if (!tx_cal_busy_s) begin
                        tx_state_d = TX_LOCK;
                        tx_cnt_d   = '0;
                    end
                end
                TX_LOCK: begin
                    if (tx_cnt_q == C_TX_LOCK) begin
                        tx_state_d = TX_READY;
                        tx_cnt_d   = '0;
                    end else if (pll_locked_s) begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end else begin
                        tx_cnt_d = '0;
                    end
                end
                TX_READY: begin
                    if (!pll_locked_s) begin
                        tx_state_d = TX_LOCK;
                        tx_cnt_d   = '0;
                    end
                end
                default: begin
                    tx_state_d = TX_PLL_PD;
                    tx_cnt_d   = '0;
                end
            endcase
        end
    end

    // RX is gated on the registered tx_ready: losing TX anywhere past
    // RX_ANALOG drops RX back to holding its analog reset.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_tmo_d   = rx_tmo_q;
        retry_d    = retry_q;
        if (tx_reset_req_i || rx_reset_req_i) begin
            rx_state_d = RX_ANALOG;
            rx_cnt_d   = '0;
            rx_tmo_d   = '0;
        end else begin
            case (rx_state_q)
                RX_ANALOG: begin
                    if ((rx_cnt_q >= C_ANA_MIN) && !rx_cal_busy_s && tx_rdy_q) begin
                        rx_state_d = RX_WAIT_CDR;
                        rx_cnt_d   = '0;
                        rx_tmo_d   = '0;
                    end else if (rx_cnt_q < C_ANA_MIN) begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
                RX_WAIT_CDR: begin
                    if (!tx_rdy_q) begin
                        rx_state_d = RX_ANALOG;
                        rx_cnt_d   = '0;
                        rx_tmo_d   = '0;
                    end else if (rx_cnt_q == C_RX_LTD) begin
                        rx_state_d = RX_READY;
                        rx_cnt_d   = '0;
                        rx_tmo_d   = '0;
                    end else if (rx_tmo_q == C_CDR_TMO) begin
                        rx_state_d = RX_ANALOG;
                        rx_cnt_d   = '0;
                        rx_tmo_d   = '0;
                        if (retry_q != 8'hFF) begin
                            retry_d = retry_q + 8'd1;
                        end
                    end else begin
                        rx_cnt_d = rx_ltd_s ? (rx_cnt_q + 1'b1) : '0;
                        rx_tmo_d = rx_tmo_q + 1'b1;
                    end
                end
                RX_READY: begin
                    if (!tx_rdy_q) begin
                        rx_state_d = RX_ANALOG;
                        rx_cnt_d   = '0;
                        rx_tmo_d   = '0;
                    end else if (!rx_ltd_s) begin
                        rx_state_d = RX_WAIT_CDR;
                        rx_cnt_d   = '0;
                        rx_tmo_d   = '0;
                    end
                end
                default: begin
                    rx_state_d = RX_ANALOG;
                    rx_cnt_d   = '0;
                    rx_tmo_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state they belong to.
    always_comb begin
        pll_pd_d = (tx_state_d == TX_PLL_PD);
        tx_ana_d = (tx_state_d == TX_PLL_PD) || (tx_state_d == TX_CAL);
        tx_dig_d = (tx_state_d != TX_READY);
        tx_rdy_d = (tx_state_d == TX_READY);
        rx_ana_d = (rx_state_d == RX_ANALOG);
        rx_dig_d = (rx_state_d != RX_READY);
        rx_rdy_d = (rx_state_d == RX_READY);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tx_state_q <= TX_PLL_PD;
            rx_state_q <= RX_ANALOG;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            rx_tmo_q   <= '0;
            retry_q    <= '0;
            pll_pd_q   <= 1'b1;
            tx_ana_q   <= 1'b1;
            tx_dig_q   <= 1'b1;
            rx_ana_q   <= 1'b1;
            rx_dig_q   <= 1'b1;
            tx_rdy_q   <= 1'b0;
            rx_rdy_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_tmo_q   <= rx_tmo_d;
            retry_q    <= retry_d;
            pll_pd_q   <= pll_pd_d;
            tx_ana_q   <= tx_ana_d;
            tx_dig_q   <= tx_dig_d;
            rx_ana_q   <= rx_ana_d;
            rx_dig_q   <= rx_dig_d;
            tx_rdy_q   <= tx_rdy_d;
            rx_rdy_q   <= rx_rdy_d;
        end
    end

    assign pll_powerdown_o   = pll_pd_q;
    assign tx_analogreset_o  = tx_ana_q;
    assign tx_digitalreset_o = tx_dig_q;
    assign rx_analogreset_o  = rx_ana_q;
    assign rx_digitalreset_o = rx_dig_q;
    assign tx_ready_o        = tx_rdy_q;
    assign rx_ready_o        = rx_rdy_q;
    assign rx_retry_cnt_o    = retry_q;

endmodule

// File: tb/tb_wr_arria10_xcvr_rst_seq.sv
// Bench for wr_arria10_xcvr_rst_seq. Each scenario computes, from the
// sequencing rules and its random timing parameters, the edges at which the
// output vector must change and queues them; a negedge monitor pops and
// compares whenever the outputs actually change.
module tb_wr_arria10_xcvr_rst_seq;

    localparam int P_PD   = 8;
    localparam int P_MIN  = 6;
    localparam int P_LOCK = 4;
    localparam int P_LTD  = 10;
    localparam int P_TMO  = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_req = 1'b0, rx_req = 1'b0;
    logic pll_locked = 1'b0, tx_cal_busy = 1'b1, rx_ltd = 1'b0, rx_cal_busy = 1'b1;
    logic pd, ta, td, ra, rd, txr, rxr;
    logic [7:0] retry;
    logic [14:0] vec;

    wr_arria10_xcvr_rst_seq #(
        .G_PLL_PD_CYCLES    (P_PD),
        .G_ANALOG_MIN_CYCLES(P_MIN),
        .G_TX_LOCK_CYCLES   (P_LOCK),
        .G_RX_LTD_CYCLES    (P_LTD),
        .G_CDR_TIMEOUT      (P_TMO)
    ) dut (
        .clock_i             (clk),
        .reset_i             (rst),
        .tx_reset_req_i      (tx_req),
        .rx_reset_req_i      (rx_req),
        .pll_locked_i        (pll_locked),
        .tx_cal_busy_i       (tx_cal_busy),
        .rx_is_lockedtodata_i(rx_ltd),
        .rx_cal_busy_i       (rx_cal_busy),
        .pll_powerdown_o     (pd),
        .tx_analogreset_o    (ta),
        .tx_digitalreset_o   (td),
        .rx_analogreset_o    (ra),
        .rx_digitalreset_o   (rd),
        .tx_ready_o          (txr),
        .rx_ready_o          (rxr),
        .rx_retry_cnt_o      (retry)
    );

    always #5 clk = ~clk;

    assign vec = {pd, ta, td, ra, rd, txr, rxr, retry};

    typedef struct {
        int          cyc;
        logic [14:0] v;
    } ev_t;

    ev_t         evq[$];
    int          cyc = 0;
    int          base = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [14:0] prev;
    string       scn = "init";

    bit       m_pd, m_ta, m_txr, m_ra, m_rxr;
    logic [7:0] m_ret;

    function automatic logic [14:0] mkv(input bit p, input bit a, input bit tr,
                                        input bit r, input bit rr, input logic [7:0] c);
        return {p, a, ~tr, r, ~rr, tr, rr, c};
    endfunction

    localparam logic [14:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && (vec !== prev)) begin
            checks++;
            if (evq.size() == 0) begin
                errors++;
                $display("FAIL %s unexpected_change: edge %0d outputs %h, required to stay %h",
                         scn, cyc - base, vec, prev);
            end else begin
                ev_t e;
                e = evq.pop_front();
                if ((e.cyc != cyc) || (e.v !== vec)) begin
                    errors++;
                    $display("FAIL %s output_event: edge %0d outputs %h, required edge %0d outputs %h",
                             scn, cyc - base, vec, e.cyc - base, e.v);
                end
            end
            prev = vec;
        end
    end

    task automatic ev(input int rel);
        ev_t e;
        e.cyc = base + rel;
        e.v   = mkv(m_pd, m_ta, m_txr, m_ra, m_rxr, m_ret);
        evq.push_back(e);
    endtask

    // Returns 1 ns after the negedge that follows relative edge rel.
    task automatic at_edge(input int rel);
        while (cyc < base + rel) @(negedge clk);
        #1;
    endtask

    task automatic start_scn(input string name, input logic pl, input logic tb,
                             input logic lt, input logic rb);
        mon_en      = 1'b0;
        rst         = 1'b1;
        tx_req      = 1'b0;
        rx_req      = 1'b0;
        pll_locked  = pl;
        tx_cal_busy = tb;
        rx_ltd      = lt;
        rx_cal_busy = rb;
        evq.delete();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (vec !== RESET_VEC) begin
            errors++;
            $display("FAIL %s reset_state: outputs %h, required %h", name, vec, RESET_VEC);
        end
        rst   = 1'b0;
        base  = cyc;
        prev  = RESET_VEC;
        scn   = name;
        m_pd  = 1'b1; m_ta = 1'b1; m_txr = 1'b0; m_ra = 1'b1; m_rxr = 1'b0; m_ret = 8'd0;
        mon_en = 1'b1;
    endtask

    task automatic end_scn(input int rel);
        at_edge(rel);
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL %s pending_events: %0d outstanding at edge %0d, required 0 (next at edge %0d outputs %h)",
                     scn, evq.size(), cyc - base, evq[0].cyc - base, evq[0].v);
        end
        mon_en = 1'b0;
        evq.delete();
    endtask

    // Nominal TX/RX release edges when all status is good from release.
    localparam int E_TA = P_PD + 1;
    localparam int E_TR = E_TA + P_LOCK + 1;
    localparam int E_TW = E_TR + 1;
    localparam int E_RR = E_TW + P_LTD + 1;

    task automatic nominal_events();
        m_pd = 1'b0;  ev(P_PD);
        m_ta = 1'b0;  ev(E_TA);
        m_txr = 1'b1; ev(E_TR);
        m_ra = 1'b0;  ev(E_TW);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required to finish earlier");
        $fatal(1);
    end

    initial begin
        // Nominal bring-up with random calibration release times.
        for (int it = 0; it < 3; it++) begin
            int cb, rb, t_a, t_r, t_w, last;
            cb = $urandom_range(0, 12);
            rb = $urandom_range(0, 30);
            start_scn("nominal", 1'b1, 1'b1, 1'b1, 1'b1);
            t_a = (cb + 3 > P_PD + 1) ? cb + 3 : P_PD + 1;
            t_r = t_a + P_LOCK + 1;
            t_w = P_MIN + 1;
            if (t_r + 1 > t_w) t_w = t_r + 1;
            if (rb + 3 > t_w) t_w = rb + 3;
            m_pd = 1'b0;  ev(P_PD);
            m_ta = 1'b0;  ev(t_a);
            m_txr = 1'b1; ev(t_r);
            m_ra = 1'b0;  ev(t_w);
            m_rxr = 1'b1; ev(t_w + P_LTD + 1);
            last = (cb > rb) ? cb : rb;
            for (int k = 0; k <= last; k++) begin
                at_edge(k);
                if (k == cb) tx_cal_busy = 1'b0;
                if (k == rb) rx_cal_busy = 1'b0;
            end
            end_scn(t_w + P_LTD + 6);
        end

        // Glitchy CDR: one low cycle during the stability window.
        for (int it = 0; it < 2; it++) begin
            int g;
            g = $urandom_range(E_TW - 2, E_TW + P_LTD - 3);
            start_scn("glitch_cdr", 1'b1, 1'b0, 1'b1, 1'b0);
            nominal_events();
            m_rxr = 1'b1; ev(g + 3 + P_LTD + 1);
            at_edge(g);     rx_ltd = 1'b0;
            at_edge(g + 1); rx_ltd = 1'b1;
            end_scn(g + P_LTD + 10);
        end

        // PLL lock lost for 5 cycles with both sides ready.
        for (int it = 0; it < 2; it++) begin
            int d;
            d = $urandom_range(E_RR + 4, E_RR + 14);
            start_scn("pll_drop", 1'b1, 1'b0, 1'b1, 1'b0);
            nominal_events();
            m_rxr = 1'b1; ev(E_RR);
            m_txr = 1'b0; ev(d + 3);
            m_rxr = 1'b0; m_ra = 1'b1; ev(d + 4);
            m_txr = 1'b1; ev(d + 3 + 5 + P_LOCK);
            m_ra = 1'b0;  ev(d + 4 + 5 + P_LOCK);
            m_rxr = 1'b1; ev(d + 4 + 5 + P_LOCK + P_LTD + 1);
            at_edge(d);     pll_locked = 1'b0;
            at_edge(d + 5); pll_locked = 1'b1;
            end_scn(d + 30);
        end

        // tx_reset_req mid-RX_WAIT_CDR, optionally with rx_reset_req, then an
        // rx_reset_req alone once TX is back.
        for (int it = 0; it < 2; it++) begin
            int q, r;
            bit both;
            q = $urandom_range(E_TW + 1, E_TW + 45);
            r = q + 20 + $urandom_range(0, 10);
            both = 1'($urandom_range(0, 1));
            start_scn("tx_req", 1'b1, 1'b0, 1'b0, 1'b0);
            nominal_events();
            m_pd = 1'b1; m_ta = 1'b1; m_txr = 1'b0; m_ra = 1'b1; ev(q + 1);
            m_pd = 1'b0;  ev(q + 1 + P_PD);
            m_ta = 1'b0;  ev(q + 2 + P_PD);
            m_txr = 1'b1; ev(q + 3 + P_PD + P_LOCK);
            m_ra = 1'b0;  ev(q + 4 + P_PD + P_LOCK);
            m_ra = 1'b1;  ev(r + 1);
            m_ra = 1'b0;  ev(r + 2 + P_MIN);
            at_edge(q);     tx_req = 1'b1; rx_req = both;
            at_edge(q + 1); tx_req = 1'b0; rx_req = 1'b0;
            at_edge(r);     rx_req = 1'b1;
            at_edge(r + 1); rx_req = 1'b0;
            end_scn(r + 15);
        end

        // CDR never locks: periodic retries, counter saturating at 255.
        begin
            int k;
            start_scn("cdr_never", 1'b1, 1'b0, 1'b0, 1'b0);
            m_pd = 1'b0;  ev(P_PD);
            m_ta = 1'b0;  ev(E_TA);
            m_txr = 1'b1; ev(E_TR);
            k = E_TW;
            for (int n = 1; n <= 258; n++) begin
                m_ra = 1'b0; ev(k);
                m_ra = 1'b1; m_ret = 8'((n > 255) ? 255 : n); ev(k + P_TMO + 1);
                k = k + P_TMO + 1 + P_MIN + 1;
            end
            m_ra = 1'b0; ev(k);
            end_scn(k + 5);
        end

        // Async reset while TX sits in TX_LOCK after a retry was counted.
        begin
            start_scn("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
            nominal_events();
            m_ra = 1'b1; m_ret = 8'd1; ev(E_TW + P_TMO + 1);
            m_txr = 1'b0; ev(71);
            at_edge(68); pll_locked = 1'b0;
            end_scn(80);
            rst = 1'b1;
            #1;
            checks++;
            if (vec !== RESET_VEC) begin
                errors++;
                $display("FAIL async_reset: outputs %h without a clock edge, required %h", vec, RESET_VEC);
            end
            checks++;
            if (retry !== 8'd0) begin
                errors++;
                $display("FAIL async_retry_clear: rx_retry_cnt %0d, required 0", retry);
            end
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
